// File: rtl/reg_arbiter_if.sv
// reg_arbiter bus: requester handshake plus the shared register's strobes.
// The arbiter takes the slave view; agents and the register take master.
interface reg_arbiter_if #(
    parameter int N = 6,
    parameter int R = 4
);
    logic [R-1:0]   req;
    logic [R-1:0]   we;
    logic [R*N-1:0] wdata;
    logic [R-1:0]   gnt;
    logic [R-1:0]   ack;
    logic [N-1:0]   rdata;
    logic           busy;
    logic           reg_write;
    logic           reg_read;
    logic [N-1:0]   reg_din;
    logic [N-1:0]   reg_dout;

    modport slave (
        input  req, we, wdata, reg_dout,
        output gnt, ack, rdata, busy,
        output reg_write, reg_read, reg_din
    );

    modport master (
        output req, we, wdata, reg_dout,
        input  gnt, ack, rdata, busy,
        input  reg_write, reg_read, reg_din
    );
endinterface

// File: rtl/reg_arbiter.sv
// Round-robin arbiter sharing one N-bit register among R requesters.
// One transaction at a time: IDLE -> ISSUE -> (WAIT) -> DONE.
module reg_arbiter #(
    parameter int N = 6,
    parameter int R = 4
) (
    input  logic          clk,
    input  logic          rst,
    reg_arbiter_if.slave  bus
);
    localparam int IW = (R > 1) ? $clog2(R) : 1;
    localparam logic [R-1:0] ONE = R'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] idx;
    logic          op_we;

    logic          win_found;
    logic [IW-1:0] win_idx;
    logic          win_we;
    logic [N-1:0]  win_data;
    int            sel;

    // Pick the first requester at or above ptr, wrapping modulo R.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_we    = 1'b0;
        win_data  = '0;
        sel       = 0;
        for (int i = 0; i < R; i++) begin
            sel = int'(ptr) + i;
            if (sel >= R)
                sel = sel - R;
            if (!win_found && bus.req[sel]) begin
                win_found = 1'b1;
                win_idx   = IW'(sel);
                win_we    = bus.we[sel];
                win_data  = bus.wdata[sel*N +: N];
            end
        end
    end

    // Sequencer with registered grant, strobes, ack and read data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            ptr           <= '0;
            idx           <= '0;
            op_we         <= 1'b0;
            bus.gnt       <= '0;
            bus.ack       <= '0;
            bus.rdata     <= '0;
            bus.busy      <= 1'b0;
            bus.reg_write <= 1'b0;
            bus.reg_read  <= 1'b0;
            bus.reg_din   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (win_found) begin
                        state         <= ISSUE;
                        idx           <= win_idx;
                        op_we         <= win_we;
                        bus.gnt       <= ONE << win_idx;
                        bus.busy      <= 1'b1;
                        bus.reg_write <= win_we;
                        bus.reg_read  <= !win_we;
                        bus.reg_din   <= win_we ? win_data : '0;
                    end
                end
                ISSUE: begin
                    bus.reg_write <= 1'b0;
                    bus.reg_read  <= 1'b0;
                    bus.reg_din   <= '0;
                    if (op_we) begin
                        state   <= DONE;
                        bus.ack <= bus.gnt;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    bus.rdata <= bus.reg_dout;
                    bus.ack   <= bus.gnt;
                    state     <= DONE;
                end
                DONE: begin
                    bus.ack  <= '0;
                    bus.gnt  <= '0;
                    bus.busy <= 1'b0;
                    ptr      <= (idx == IW'(R - 1)) ? '0 : idx + 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_arbiter.sv
// Directed bench for reg_arbiter with a behavioural shared register.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_reg_arbiter;
    localparam int N = 6;
    localparam int R = 4;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;
    logic [N-1:0] mem;

    reg_arbiter_if #(.N(N), .R(R)) bus ();

    reg_arbiter #(.N(N), .R(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared register: write on strobe, dout valid the cycle after read.
    always @(posedge clk) begin
        if (bus.reg_write)
            mem <= bus.reg_din;
        if (bus.reg_read)
            bus.reg_dout <= mem;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait for the DONE cycle (bounded) and check who got the ack.
    task automatic await_ack(input string tag, input logic [R-1:0] exp);
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (bus.ack != '0)
                break;
        end
        chk({tag, "_ack"}, 32'(bus.ack), 32'(exp));
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'(exp));
    endtask

    task automatic idle();
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 0);
    endtask

    int order [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b0;
        bus.req = 4'b1111;
        bus.we = 4'b1111;
        bus.wdata = '0;

        // Reset held two cycles with every requester asking.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_wr", 32'(bus.reg_write), 0);
        chk("rst_rd", 32'(bus.reg_read), 0);
        chk("rst_din", 32'(bus.reg_din), 0);
        chk("rst_rdata", 32'(bus.rdata), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        rst = 1'b1;

        // Fairness: all four held, order 0,1,2,3,0,1.
        for (int i = 0; i < 6; i++)
            await_ack($sformatf("rr%0d", i), R'(1) << order[i]);
        bus.req = '0;
        idle();

        // Requester 2 write: strobe at t+1, ack at t+2.
        bus.req = 4'b0100;
        bus.we = 4'b0100;
        bus.wdata[2*N +: N] = 6'b101101;
        @(negedge clk);
        chk("wr_strobe", 32'(bus.reg_write), 1);
        chk("wr_rd_low", 32'(bus.reg_read), 0);
        chk("wr_din", 32'(bus.reg_din), 32'h2d);
        chk("wr_gnt", 32'(bus.gnt), 32'h4);
        @(negedge clk);
        chk("wr_ack", 32'(bus.ack), 32'h4);
        chk("wr_strobe_off", 32'(bus.reg_write), 0);
        bus.req = '0;
        idle();

        // Requester 2 read: strobe t+1, wait t+2, ack t+3.
        bus.req = 4'b0100;
        bus.we = 4'b0000;
        @(negedge clk);
        chk("rd_strobe", 32'(bus.reg_read), 1);
        chk("rd_wr_low", 32'(bus.reg_write), 0);
        chk("rd_din_zero", 32'(bus.reg_din), 0);
        @(negedge clk);
        chk("rd_wait_ack", 32'(bus.ack), 0);
        chk("rd_wait_busy", 32'(bus.busy), 1);
        chk("rd_wait_strobe", 32'(bus.reg_read), 0);
        @(negedge clk);
        chk("rd_ack", 32'(bus.ack), 32'h4);
        chk("rd_data", 32'(bus.rdata), 32'h2d);
        bus.req = '0;
        idle();

        // Rotation: serve 3, then 1001 wraps to 0, then 3.
        bus.req = 4'b1000;
        bus.we = 4'b1001;
        bus.wdata[3*N +: N] = 6'h07;
        bus.wdata[0 +: N] = 6'h11;
        await_ack("rot3", 4'b1000);
        bus.req = 4'b1001;
        await_ack("rot0", 4'b0001);
        bus.req = 4'b1000;
        await_ack("rot3b", 4'b1000);
        bus.req = '0;
        idle();

        // Data isolation: wdata change during ISSUE is ignored.
        bus.req = 4'b0010;
        bus.we = 4'b0010;
        bus.wdata[1*N +: N] = 6'h15;
        @(negedge clk);
        chk("iso_din", 32'(bus.reg_din), 32'h15);
        bus.wdata[1*N +: N] = 6'h2a;
        bus.we = 4'b0000;
        await_ack("iso_wr", 4'b0010);
        bus.req = '0;
        idle();
        bus.req = 4'b0010;
        bus.we = 4'b0000;
        await_ack("iso_rd", 4'b0010);
        chk("iso_rdata", 32'(bus.rdata), 32'h15);
        bus.req = '0;
        idle();

        // Reset during WAIT of a requester 3 read.
        bus.req = 4'b1000;
        bus.we = 4'b0000;
        @(negedge clk);
        chk("mr_strobe", 32'(bus.reg_read), 1);
        @(negedge clk);
        chk("mr_wait_busy", 32'(bus.busy), 1);
        rst = 1'b0;
        bus.req = 4'b1010;
        @(negedge clk);
        chk("mr_ack", 32'(bus.ack), 0);
        chk("mr_gnt", 32'(bus.gnt), 0);
        chk("mr_busy", 32'(bus.busy), 0);
        chk("mr_rdata", 32'(bus.rdata), 0);
        rst = 1'b1;
        await_ack("mr_first", 4'b0010);
        chk("mr_first_data", 32'(bus.rdata), 32'h15);
        bus.req = 4'b1000;
        await_ack("mr_retry", 4'b1000);
        chk("mr_retry_data", 32'(bus.rdata), 32'h15);
        bus.req = '0;
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/reg_arbiter.md
# reg_arbiter

Round-robin arbiter and sequencer that shares a single N-bit storage register (write/read/din/dout style register block) among R requesters. Each requester issues a single write or read transaction. The arbiter grants one requester at a time and drives the register's write/read strobes and data input. It returns read data with a one-cycle acknowledge. It sits between the requester agents and the register instance, which no requester drives directly.

## Interface

**Parameters**
- N, 6, data width; matches the register's width
- R, 4, number of requesters; 2..8

**Ports**
- Timing
  - One clock; reset is synchronous and active-low.
  - clk, input, 1: rising-edge clock
  - rst, input, 1: synchronous, active-low reset, sampled on the rising edge of clk
- Requester side
  - req, input, R: per-requester transaction request; level, held until ack
  - we, input, R: per-requester direction; 1 = write, 0 = read
  - wdata, input, R*N: write data; requester i occupies bits [i*N +: N]
  - gnt, output, R: one-hot grant, held for the whole transaction
  - ack, output, R: one-cycle completion pulse to the granted requester
  - rdata, output, N: read data, valid while the ack bit of a read is high
  - busy, output, 1: high in any state other than IDLE
- Register side
  - reg_write, output, 1: register write strobe
  - reg_read, output, 1: register read strobe
  - reg_din, output, N: register data in
  - reg_dout, input, N: register data out; valid the cycle after reg_read

## Operation

**FSM states:** IDLE, ISSUE, WAIT, DONE.

- **IDLE**
  - Evaluate req with round-robin priority, starting at pointer ptr and ascending modulo R.
  - If any req bit is set, register the winner k:
    - gnt = one-hot(k)
    - latch op_we = we[k]
    - latch op_data = wdata slice k
  - Go to ISSUE.
  - With no req, stay in IDLE and drive all outputs low.
- **ISSUE**
  - Drive reg_write = op_we and reg_read = !op_we for exactly this one cycle.
  - Drive reg_din = op_data; reg_din is 0 whenever reg_write is low.
  - Next state: write → DONE; read → WAIT.
- **WAIT** (reads only)
  - Capture reg_dout into rdata at the end of this cycle.
  - Go to DONE.
- **DONE**
  - ack[k] = 1 and gnt is still asserted.
  - Set ptr = (k+1) mod R.
  - Return to IDLE. req is ignored in this state.
- **Grant stability:** gnt does not change between IDLE exit and DONE exit. Changes to req, we or wdata after the grant have no effect on the transaction in progress.
- **Requester obligation:** deassert req on the clock edge where ack is sampled high. A req still high in the following IDLE cycle is treated as a new transaction.
- **Rotation:** the requester just served becomes lowest priority, so no requester starves while others hold req.
- **Data retention:** rdata keeps its last read value between reads. It is defined only while ack is high for a read.

## Timing

- **Reset** (rst = 0 at a rising edge), effective on that edge:
  - State returns to IDLE and ptr = 0.
  - gnt, ack, reg_write, reg_read, reg_din, rdata and busy all go to 0.
- **Reset mid-transaction:** the transaction is abandoned and no ack is issued. A register write completed in an earlier ISSUE cycle stands.
- **Write latency:** req seen in IDLE at cycle t:
  - t+1: ISSUE, reg_write high
  - t+2: DONE, ack high
  - Register contents are updated at the end of t+1.
- **Read latency:**
  - t+1: ISSUE, reg_read high
  - t+2: WAIT, reg_dout captured
  - t+3: DONE, ack high, rdata valid
- **Throughput:** back-to-back writes complete one every 3 cycles (IDLE, ISSUE, DONE); back-to-back reads complete one every 4 cycles.
- **Mutual exclusion:** reg_write and reg_read are never high in the same cycle. Each is high for at most one cycle per transaction.
- **Simultaneous requests:** the lowest index at or above ptr (with wrap) wins. A requester joining during ISSUE, WAIT or DONE is considered at the next IDLE.
- **Pointer wrap:** after requester R-1 is served, ptr = 0.
- **busy:** equals (state != IDLE).

## Test plan

- **Reset:** hold rst = 0 for 2 cycles with req = all ones → all outputs 0, no strobe. After release, requester 0 is granted first (ptr = 0).
- **Single write then read:** requester 2 writes 6'b101101, then reads.
  - Write: reg_write high for 1 cycle with reg_din = 101101; ack[2] arrives 2 cycles after the IDLE sample.
  - Read: ack[2] arrives 3 cycles after the sample, with rdata = 101101.
- **Round-robin fairness:** req = 4'b1111 held, with each requester re-asserting after its ack → grant order 0,1,2,3,0,1. No grant repeats before all others are served.
- **Priority rotation:** after requester 3 is served, req = 4'b1001 → requester 0 is granted (wrap), then requester 3.
- **Data isolation:** requester 1 changes wdata from 6'h15 to 6'h2A during ISSUE → register captures 6'h15. A later read returns 6'h15.
- **Reset mid-read:** assert rst = 0 in WAIT → no ack. After release, the same requester (req still high) is re-granted from ptr = 0 ordering and completes normally.
